// File: rtl/dcache_line_swap_ctrl.sv
// Services one L1 D-cache miss: optional eviction of the displaced line into the
// victim cache, then a two-beat bus fill written half by half into the chosen way.
module dcache_line_swap_ctrl #(
  parameter int AWT           = 32,
  parameter int WORD_SEL      = 4,
  parameter int L1_WAYS       = 2,
  parameter int WAY_IDX_WT    = 1,
  parameter int VC_WAYS_EXP   = 2,
  parameter int HALF_LINE_DWT = 256,
  parameter int LINE_DWT      = 512
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AWT-1:0]               req_addr_i,
  input  logic [WAY_IDX_WT-1:0]        req_way_i,
  input  logic                         req_evict_i,
  input  logic [AWT-1:0]               req_evict_addr_i,
  output logic [L1_WAYS-1:0]           rd_en_o,
  output logic [1:0]                   rd_half_en_o,
  output logic [AWT-1:0]               rd_addr_o,
  input  logic [HALF_LINE_DWT-1:0]     rd_halfdata_i,
  input  logic                         rd_wr_conflict_i,
  output logic                         vc_wr_en_o,
  output logic                         vc_line_en_o,
  output logic [VC_WAYS_EXP-1:0]       vc_way_o,
  output logic [LINE_DWT-1:0]          vc_data_o,
  output logic                         vc_tag_en_o,
  output logic [AWT-WORD_SEL-3:0]      vc_tag_o,
  output logic                         fill_req_o,
  output logic [AWT-1:0]               fill_addr_o,
  input  logic                         fill_ack_i,
  input  logic                         fill_valid_i,
  input  logic [HALF_LINE_DWT-1:0]     fill_data_i,
  output logic [L1_WAYS-1:0]           wr_en_o,
  output logic [1:0]                   wr_half_en_o,
  output logic [AWT-1:0]               wr_addr_o,
  output logic [HALF_LINE_DWT-1:0]     wr_data_o,
  output logic [L1_WAYS-1:0]           wr_tag_en_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int OFF   = WORD_SEL + 2;
  localparam int TAG_W = AWT - OFF;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_EV_RD_LO = 4'd1;
  localparam logic [3:0] S_EV_RD_HI = 4'd2;
  localparam logic [3:0] S_EV_CAP   = 4'd3;
  localparam logic [3:0] S_VC_WR    = 4'd4;
  localparam logic [3:0] S_FILL_REQ = 4'd5;
  localparam logic [3:0] S_FILL_LO  = 4'd6;
  localparam logic [3:0] S_FILL_HI  = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]               state_q, state_d;
  logic [TAG_W-1:0]         line_addr_q, line_addr_d;
  logic [WAY_IDX_WT-1:0]    way_q, way_d;
  logic [AWT-1:0]           evict_addr_q, evict_addr_d;
  logic [VC_WAYS_EXP-1:0]   vc_ptr_q, vc_ptr_d;
  logic [HALF_LINE_DWT-1:0] lo_q, lo_d, hi_q, hi_d;
  logic                     lo_taken_q, lo_taken_d;
  logic                     wr_pend_q, wr_pend_d;
  logic [HALF_LINE_DWT-1:0] wr_data_q, wr_data_d;
  logic [HALF_LINE_DWT-1:0] buf_q, buf_d;
  logic                     buf_vld_q, buf_vld_d;

  logic [L1_WAYS-1:0]       way_oh;
  logic                     wr_issue;

  for (genvar gi = 0; gi < L1_WAYS; gi++) begin : g_way_oh
    assign way_oh[gi] = (way_q == WAY_IDX_WT'(gi));
  end

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    way_d        = way_q;
    evict_addr_d = evict_addr_q;
    vc_ptr_d     = vc_ptr_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    lo_taken_d   = lo_taken_q;
    wr_pend_d    = wr_pend_q;
    wr_data_d    = wr_data_q;
    buf_d        = buf_q;
    buf_vld_d    = buf_vld_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          line_addr_d  = req_addr_i[AWT-1:OFF];
          way_d        = req_way_i;
          evict_addr_d = req_evict_addr_i;
          lo_taken_d   = 1'b0;
          wr_pend_d    = 1'b0;
          buf_vld_d    = 1'b0;
          state_d      = req_evict_i ? S_EV_RD_LO : S_FILL_REQ;
        end
      end
      S_EV_RD_LO: if (!rd_wr_conflict_i) state_d = S_EV_RD_HI;
      S_EV_RD_HI: begin
        // The low half arrives only in the first cycle here; retries must not overwrite it.
        if (!lo_taken_q) begin
          lo_d       = rd_halfdata_i;
          lo_taken_d = 1'b1;
        end
        if (!rd_wr_conflict_i) state_d = S_EV_CAP;
      end
      S_EV_CAP: begin
        hi_d    = rd_halfdata_i;
        state_d = S_VC_WR;
      end
      S_VC_WR: begin
        vc_ptr_d = vc_ptr_q + VC_WAYS_EXP'(1);
        state_d  = S_FILL_REQ;
      end
      S_FILL_REQ: if (fill_ack_i) state_d = S_FILL_LO;
      S_FILL_LO: begin
        if (wr_pend_q) begin
          wr_pend_d = 1'b0;
          state_d   = S_FILL_HI;
          // A high beat landing during the low write is parked until FILL_HI.
          if (fill_valid_i) begin
            buf_d     = fill_data_i;
            buf_vld_d = 1'b1;
          end
        end else if (fill_valid_i) begin
          wr_data_d = fill_data_i;
          wr_pend_d = 1'b1;
        end
      end
      S_FILL_HI: begin
        if (wr_pend_q) begin
          wr_pend_d = 1'b0;
          state_d   = S_DONE;
        end else if (buf_vld_q) begin
          wr_data_d = buf_q;
          buf_vld_d = 1'b0;
          wr_pend_d = 1'b1;
        end else if (fill_valid_i) begin
          wr_data_d = fill_data_i;
          wr_pend_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      line_addr_q  <= '0;
      way_q        <= '0;
      evict_addr_q <= '0;
      vc_ptr_q     <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      lo_taken_q   <= 1'b0;
      wr_pend_q    <= 1'b0;
      wr_data_q    <= '0;
      buf_q        <= '0;
      buf_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      way_q        <= way_d;
      evict_addr_q <= evict_addr_d;
      vc_ptr_q     <= vc_ptr_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      lo_taken_q   <= lo_taken_d;
      wr_pend_q    <= wr_pend_d;
      wr_data_q    <= wr_data_d;
      buf_q        <= buf_d;
      buf_vld_q    <= buf_vld_d;
    end
  end

  assign wr_issue = wr_pend_q && ((state_q == S_FILL_LO) || (state_q == S_FILL_HI));

  assign req_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign rd_en_o      = ((state_q == S_EV_RD_LO) || (state_q == S_EV_RD_HI)) ? way_oh : '0;
  assign rd_half_en_o = (state_q == S_EV_RD_LO) ? 2'b10 :
                        (state_q == S_EV_RD_HI) ? 2'b11 : 2'b00;
  assign rd_addr_o    = evict_addr_q;
  assign vc_wr_en_o   = (state_q == S_VC_WR);
  assign vc_line_en_o = vc_wr_en_o;
  assign vc_tag_en_o  = vc_wr_en_o;
  assign vc_way_o     = vc_ptr_q;
  assign vc_data_o    = {hi_q, lo_q};
  assign vc_tag_o     = evict_addr_q[AWT-1:OFF];
  assign fill_req_o   = (state_q == S_FILL_REQ);
  assign fill_addr_o  = {line_addr_q, {OFF{1'b0}}};
  assign wr_en_o      = wr_issue ? way_oh : '0;
  assign wr_half_en_o = !wr_issue ? 2'b00 : (state_q == S_FILL_HI) ? 2'b11 : 2'b10;
  assign wr_addr_o    = fill_addr_o;
  assign wr_data_o    = wr_data_q;
  assign wr_tag_en_o  = (wr_issue && (state_q == S_FILL_HI)) ? way_oh : '0;

endmodule

// File: tb/tb_dcache_line_swap_ctrl.sv
// Directed and randomized miss services, each checked against a request-level
// model: expected reads, VC write, fill writes, round-robin VC way and latency.
module tb_dcache_line_swap_ctrl;
  localparam int AWT = 32, WS = 4, LW = 2, WIW = 1, VCE = 2, HD = 256, LD = 512;
  localparam int OFF = WS + 2;

  logic clk_i = 1'b0, rst_i = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o, req_evict_i = 1'b0;
  logic [AWT-1:0] req_addr_i = '0, req_evict_addr_i = '0;
  logic [WIW-1:0] req_way_i = '0;
  logic [LW-1:0] rd_en_o, wr_en_o, wr_tag_en_o;
  logic [1:0] rd_half_en_o, wr_half_en_o;
  logic [AWT-1:0] rd_addr_o, fill_addr_o, wr_addr_o;
  logic [HD-1:0] rd_halfdata_i = '0, fill_data_i = '0, wr_data_o;
  logic rd_wr_conflict_i = 1'b0, fill_ack_i = 1'b0, fill_valid_i = 1'b0;
  logic vc_wr_en_o, vc_line_en_o, vc_tag_en_o, fill_req_o, busy_o, done_o;
  logic [VCE-1:0] vc_way_o;
  logic [LD-1:0] vc_data_o;
  logic [AWT-OFF-1:0] vc_tag_o;

  int total = 0, bad = 0;
  int exp_ptr = 0;

  dcache_line_swap_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_way_i(req_way_i), .req_evict_i(req_evict_i), .req_evict_addr_i(req_evict_addr_i),
    .rd_en_o(rd_en_o), .rd_half_en_o(rd_half_en_o), .rd_addr_o(rd_addr_o),
    .rd_halfdata_i(rd_halfdata_i), .rd_wr_conflict_i(rd_wr_conflict_i),
    .vc_wr_en_o(vc_wr_en_o), .vc_line_en_o(vc_line_en_o), .vc_way_o(vc_way_o),
    .vc_data_o(vc_data_o), .vc_tag_en_o(vc_tag_en_o), .vc_tag_o(vc_tag_o),
    .fill_req_o(fill_req_o), .fill_addr_o(fill_addr_o), .fill_ack_i(fill_ack_i),
    .fill_valid_i(fill_valid_i), .fill_data_i(fill_data_i),
    .wr_en_o(wr_en_o), .wr_half_en_o(wr_half_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .wr_tag_en_o(wr_tag_en_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [LD-1:0] obs, input logic [LD-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HD-1:0] rnd_half();
    logic [HD-1:0] r;
    for (int i = 0; i < HD / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ctl"}, {req_ready_o, busy_o, done_o, rd_en_o, rd_half_en_o, vc_wr_en_o,
        vc_line_en_o, vc_tag_en_o, vc_way_o, fill_req_o, wr_en_o, wr_half_en_o, wr_tag_en_o},
        19'h40000);
    chk({tag, "_addr"}, {rd_addr_o, fill_addr_o, wr_addr_o, vc_tag_o}, '0);
    chk({tag, "_vcdata"}, vc_data_o, '0);
    chk({tag, "_wrdata"}, wr_data_o, '0);
  endtask

  // One miss service. The bench acts as way RAM (conflicts, read data) and bus
  // (ack delay d, gap g0 before the low beat, gap g1 between beats).
  task automatic run_req(input logic [AWT-1:0] addr, input logic [WIW-1:0] way, input logic ev,
                         input logic [AWT-1:0] eaddr, input logic [HD-1:0] rlo, input logic [HD-1:0] rhi,
                         input logic [HD-1:0] b0, input logic [HD-1:0] b1,
                         input int clo, input int chi, input int d, input int g0, input int g1,
                         input bit spur, input bit rst_mid);
    int nlo = 0, nhi = 0, nvc = 0, nstray_vc = 0, nwr = 0, nstray_tag = 0;
    int done_cyc = -1, fr = 0, ack_cyc = -1, clo_left = clo, chi_left = chi;
    int prev_half = 0, wr1_cyc = -1, exp_lat;
    bit aborted = 0;
    logic [LW-1:0] oh;
    logic [AWT-1:0] faddr;
    oh = LW'(1) << way;
    faddr = (addr >> OFF) << OFF;
    for (int cyc = 0; cyc < 200 && done_cyc < 0 && !aborted; cyc++) begin
      @(negedge clk_i);
      if (cyc == 0) begin
        chk("ready_idle", req_ready_o, 1'b1);
        req_valid_i = 1'b1; req_addr_i = addr; req_way_i = way;
        req_evict_i = ev; req_evict_addr_i = eaddr;
      end else if (cyc == 1) begin
        chk("ready_busy", {req_ready_o, busy_o}, 2'b01);
        req_valid_i = 1'b1; req_addr_i = $urandom; req_way_i = ~way;
        req_evict_i = ~ev; req_evict_addr_i = $urandom;
      end else begin
        req_valid_i = 1'b0;
      end
      rd_halfdata_i = (prev_half == 1) ? rlo : (prev_half == 2) ? rhi : rnd_half();
      prev_half = 0;
      rd_wr_conflict_i = 1'b0;
      if (rd_en_o != '0) begin
        chk("rd_en", rd_en_o, oh);
        chk("rd_addr", rd_addr_o, eaddr);
        if (rd_half_en_o == 2'b10) begin
          nlo++; prev_half = 1;
          if (clo_left > 0) begin rd_wr_conflict_i = 1'b1; clo_left--; end
        end else begin
          chk("rd_half", rd_half_en_o, 2'b11);
          nhi++; prev_half = 2;
          if (chi_left > 0) begin rd_wr_conflict_i = 1'b1; chi_left--; end
        end
      end
      if (vc_wr_en_o) begin
        nvc++;
        chk("vc_line_tag_en", {vc_line_en_o, vc_tag_en_o}, 2'b11);
        chk("vc_way", vc_way_o, exp_ptr[VCE-1:0]);
        chk("vc_tag", vc_tag_o, eaddr[AWT-1:OFF]);
        chk("vc_data", vc_data_o, {rhi, rlo});
      end else if (vc_line_en_o || vc_tag_en_o) begin
        nstray_vc++;
      end
      fill_ack_i = 1'b0; fill_valid_i = 1'b0; fill_data_i = rnd_half();
      if (fill_req_o) begin
        chk("fill_addr", fill_addr_o, faddr);
        if (fr == d) begin fill_ack_i = 1'b1; ack_cyc = cyc; end
        fr++;
      end
      if (ack_cyc >= 0 && cyc == ack_cyc + 1 + g0) begin fill_valid_i = 1'b1; fill_data_i = b0; end
      if (ack_cyc >= 0 && cyc == ack_cyc + 2 + g0 + g1) begin fill_valid_i = 1'b1; fill_data_i = b1; end
      if (spur && vc_wr_en_o) fill_valid_i = 1'b1;
      if (wr_en_o != '0) begin
        nwr++;
        chk("wr_en", wr_en_o, oh);
        chk("wr_addr", wr_addr_o, faddr);
        chk("wr_half", wr_half_en_o, (nwr == 1) ? 2'b10 : 2'b11);
        chk("wr_data", wr_data_o, (nwr == 1) ? b0 : b1);
        chk("wr_tag_en", wr_tag_en_o, (nwr == 2) ? oh : '0);
        if (nwr == 1) wr1_cyc = cyc;
      end else if (wr_tag_en_o != '0) begin
        nstray_tag++;
      end
      if (done_o) done_cyc = cyc;
      if (rst_mid && wr1_cyc >= 0 && cyc == wr1_cyc + 1) begin
        rst_i = 1'b1;
        #1;
        check_idle("rst_mid");
        rst_i = 1'b0;
        aborted = 1;
        exp_ptr = 0;
      end
    end
    req_valid_i = 1'b0; fill_valid_i = 1'b0; fill_ack_i = 1'b0; rd_wr_conflict_i = 1'b0;
    chk("stray_tag", nstray_tag, 0);
    chk("stray_vc", nstray_vc, 0);
    if (aborted) begin
      chk("rst_wr_count", nwr, 1);
      $display("req addr=%08h way=%0d evict=%0d reset mid-fill after %0d write(s)", addr, way, ev, nwr);
    end else begin
      exp_lat = 6 + d + (ev ? 4 + clo + chi : 0);
      chk("done_seen", done_cyc >= 0, 1'b1);
      chk("wr_count", nwr, 2);
      chk("vc_count", nvc, ev ? 1 : 0);
      chk("rd_lo_count", nlo, ev ? clo + 1 : 0);
      chk("rd_hi_count", nhi, ev ? chi + 1 : 0);
      if (g0 == 0 && g1 == 0) chk("latency", done_cyc, exp_lat);
      $display("req addr=%08h way=%0d evict=%0d vcway=%0d clo=%0d chi=%0d ack=%0d gaps=%0d/%0d done@%0d",
               addr, way, ev, exp_ptr, clo, chi, d, g0, g1, done_cyc);
      if (ev) exp_ptr = (exp_ptr + 1) % (1 << VCE);
    end
    @(negedge clk_i);
    chk("post_idle", {done_o, req_ready_o, busy_o}, 3'b010);
  endtask

  initial begin
    logic [HD-1:0] pa, pb, p1, p2;
    pa = {32{8'hAA}}; pb = {32{8'hBB}}; p1 = {32{8'h11}}; p2 = {32{8'h22}};
    repeat (3) @(negedge clk_i);
    check_idle("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    // plain fill, ack in the second FILL_REQ cycle
    run_req(32'h0000_1A40, 1'b1, 1'b0, 32'h0, '0, '0, pa, pb, 0, 0, 1, 0, 0, 1'b0, 1'b0);
    // eviction into VC way 0
    run_req(32'h0000_3000, 1'b0, 1'b1, 32'h0000_2200, p1, p2, pa, pb, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    // two conflict retries on the low read
    run_req(32'h0000_4080, 1'b1, 1'b1, 32'h0000_51C0, rnd_half(), rnd_half(), rnd_half(), rnd_half(),
            2, 0, 0, 0, 0, 1'b0, 1'b0);
    // three more evictions complete the 0,1,2,3,0 sequence
    for (int i = 0; i < 3; i++)
      run_req($urandom, WIW'($urandom), 1'b1, $urandom, rnd_half(), rnd_half(), rnd_half(), rnd_half(),
              0, i, 0, 0, 0, 1'b0, 1'b0);
    // gapped beats plus a spurious beat during VC_WR
    run_req($urandom, 1'b0, 1'b1, $urandom, rnd_half(), rnd_half(), rnd_half(), rnd_half(),
            0, 0, 0, 1, 3, 1'b1, 1'b0);
    // reset while FILL_HI waits for the second beat; pointer is nonzero beforehand
    run_req($urandom, 1'b1, 1'b0, 32'h0, '0, '0, rnd_half(), rnd_half(), 0, 0, 0, 0, 5, 1'b0, 1'b1);
    run_req($urandom, 1'b1, 1'b1, $urandom, rnd_half(), rnd_half(), rnd_half(), rnd_half(),
            1, 1, 1, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      run_req($urandom, WIW'($urandom), 1'($urandom), $urandom, rnd_half(), rnd_half(), rnd_half(),
              rnd_half(), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
